dmem_rmw_ctrl: RTL and testbench
================================

Name: dmem_rmw_ctrl

Overview:
- Data-memory access controller between the MIPS datapath's memory port (aluout/writedata/memwrite) and a word-wide synchronous-read data RAM.
- Adds byte/halfword store support (sb/sh) via two-cycle read-modify-write and sub-word load extraction (lb/lbu/lh/lhu).
- Stalls the core while a multi-cycle access is in flight.
- Word accesses (lw/sw) pass through with word-store in one cycle.

Parameters:
- ADDR_W, 6, word-address width of the RAM (64 words).
- BIG_ENDIAN, 1, 1: byte offset 0 maps to bits [31:24]; 0: byte offset 0 maps to bits [7:0].

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  core presents a memory request; held stable while stall=1.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as misaligned).
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; sub-word data taken from the low bits.
- stall  output  1  hold PC/pipeline this cycle.
- rdata  output  32  extended load result, valid when rdata_valid=1.
- rdata_valid  output  1  one-cycle pulse with the load result.
- misalign  output  1  registered one-cycle pulse when a request was rejected.
- mem_addr  output  ADDR_W  word address, equal to req_addr[ADDR_W+1:2].
- mem_we  output  1  RAM write enable.
- mem_wdata  output  32  RAM write data.
- mem_rdata  input  32  RAM read data, valid the cycle after mem_addr is presented.

Behaviour:
- FSM states: IDLE, MERGE, LRESP. Reset (reset=0, asynchronous) forces IDLE, rdata=0, rdata_valid=0, misalign=0.
- mem_we, stall and mem_wdata are combinational from state and request; with req_valid=0 in IDLE all three are 0.
- Alignment rules:
  - Half requires addr[0]=0.
  - Word requires addr[1:0]=00.
  - size=11 always misaligned.
- Misaligned request in IDLE: no write, stall=0, misalign=1 next cycle for one cycle, state stays IDLE.
- Word store in IDLE: mem_we=1, mem_wdata=req_wdata, stall=0, state stays IDLE. Latency is 1 cycle.
- Sub-word store in IDLE, cycle 0:
  - mem_we=0 and stall=1.
  - Captured into registers: lane offset, size, write data.
  - State goes to MERGE.
- MERGE, cycle 1:
  - mem_we=1, stall=0.
  - mem_wdata = mem_rdata with only the target lane(s) replaced by captured data; all other bytes are unchanged.
  - State goes to IDLE.
- Load in IDLE, cycle 0: stall=1, offset/size/unsigned captured, state goes to LRESP.
- LRESP, cycle 1:
  - stall=0.
  - Lane extracted from mem_rdata per BIG_ENDIAN, then zero- or sign-extended (word: unchanged).
  - rdata registered on the LRESP→IDLE edge; rdata_valid=1 for exactly one cycle.
  - rdata holds its value until the next load.
- Back-to-back requests: a new request is accepted in the IDLE cycle immediately after MERGE/LRESP. There are no bubbles beyond the single stall cycle.
- Byte lanes (BIG_ENDIAN=1): offset 0→[31:24], 1→[23:16], 2→[15:8], 3→[7:0]. Half offset 0→[31:16], 2→[15:0].
- Byte lanes (BIG_ENDIAN=0): the mapping is mirrored.
- Reset asserted in MERGE: no write is issued and the state returns to IDLE. The RAM word is untouched.
- Reset asserted in LRESP: rdata_valid is suppressed.
- req_valid dropping while stall=1 is a protocol violation; the behaviour is undefined, but the FSM must still return to IDLE within 1 cycle.
- Address bits above ADDR_W+1 are ignored (the address wraps modulo RAM size).

Test Plan:
- Word store then sb (BIG_ENDIAN=1): sw 0x12345678 @84; sb 0x000000AB @85 → stall high 1 cycle, RAM[21]=0x12AB5678, mem_we high only in the MERGE cycle.
- sh 0xFFFF0000 low-half data 0x0000 @86 over 0x12AB5678 → RAM[21]=0x12AB0000. sh @85 → misalign pulse 1 cycle later, RAM unchanged, no stall.
- Loads over RAM[21]=0x80AB7F00:
  - lb @84 → 0xFFFFFF80.
  - lbu @84 → 0x00000080.
  - lh @86 → 0x00007F00.
  - lw @84 → 0x80AB7F00.
  - Each rdata_valid is a single-cycle pulse, 1 stall cycle per load.
- Back-to-back sb @84 0x11, sb @87 0x22, lw @84 → RAM[21]=0x11AB7F22 and lw returns 0x11AB7F22, each sub-word op costing exactly 2 cycles.
- Assert reset=0 during the MERGE cycle of sb @84 0x33 → RAM[21] unchanged, outputs at reset values, state IDLE after release.
- BIG_ENDIAN=0: sb 0xCD @84 over 0x00000000 → RAM[21]=0x000000CD; lbu @84 → 0x000000CD.

Source files
------------

// File: rtl/dmem_rmw_ctrl.sv
// dmem_rmw_ctrl: data-memory controller adding sub-word loads and read-modify-write stores
module dmem_rmw_ctrl #(
  parameter int ADDR_W     = 6,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              misalign,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  typedef enum logic [1:0] {IDLE, MERGE, LRESP} state_t;
  state_t state_q, state_d;
  logic [1:0] off_q, off_d, size_q, size_d;
  logic uns_q, uns_d, rdata_valid_q, rdata_valid_d, misalign_q, misalign_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic bad, go, word_st;
  logic [4:0] sh;
  logic [15:0] lane;
  logic [31:0] mask, ext;
  logic unused_addr;
  always_comb begin
    bad = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    go = state_q == IDLE && req_valid && !bad;
    word_st = go && req_we && req_size == 2'b10;
    // bit position of the addressed lane; word accesses are always at 0
    sh = size_q == 2'b10 ? 5'd0 : BIG_ENDIAN ? {(size_q == 2'b00 ? 2'd3 : 2'd2) - off_q, 3'b000} : {off_q, 3'b000};
    mask = (size_q == 2'b00 ? 32'h0000_00ff : 32'h0000_ffff) << sh;
    lane = 16'(mem_rdata >> sh);
    ext = size_q == 2'b00 ? {{24{lane[7] & ~uns_q}}, lane[7:0]} : size_q == 2'b01 ? {{16{lane[15] & ~uns_q}}, lane} : mem_rdata;
    stall = go && !word_st;
    mem_we = reset && (word_st || state_q == MERGE);
    mem_wdata = state_q == MERGE ? (mem_rdata & ~mask) | ((wdata_q << sh) & mask) : word_st ? req_wdata : 32'h0;
    state_d = go ? (req_we ? (word_st ? IDLE : MERGE) : LRESP) : IDLE;
    off_d = go ? req_addr[1:0] : off_q;
    size_d = go ? req_size : size_q;
    uns_d = go ? req_unsigned : uns_q;
    wdata_d = go ? req_wdata : wdata_q;
    rdata_valid_d = state_q == LRESP;
    rdata_d = state_q == LRESP ? ext : rdata_q;
    misalign_d = state_q == IDLE && req_valid && bad;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      off_q <= 2'b00;
      size_q <= 2'b00;
      uns_q <= 1'b0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      rdata_valid_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q <= state_d;
      off_q <= off_d;
      size_q <= size_d;
      uns_q <= uns_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      misalign_q <= misalign_d;
    end
  assign mem_addr = req_addr[ADDR_W+1:2];
  assign rdata = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign misalign = misalign_q;
  assign unused_addr = ^req_addr[31:ADDR_W+2];
endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// tb_dmem_rmw_ctrl: big- and little-endian controllers driven in lockstep, checked against a byte-level memory model
module tb_dmem_rmw_ctrl;
  typedef struct packed {logic [31:0] d; logic [31:0] c;} exp_t;
  logic clk = 0, reset = 0, clr = 1;
  logic req_valid = 0, req_we = 0, req_unsigned = 0;
  logic [1:0] req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic stall_be, rdv_be, mis_be, mwe_be, stall_le, rdv_le, mis_le, mwe_le;
  logic [31:0] rd_be, mwd_be, mrd_be, rd_le, mwd_le, mrd_le;
  logic [5:0] ma_be, ma_le;
  logic [31:0] ram_be [64];
  logic [31:0] ram_le [64];
  logic [31:0] mdl [2][64];
  exp_t q_rd_be[$], q_rd_le[$];
  logic [31:0] q_mis_be[$], q_mis_le[$];
  exp_t x_be, x_le;
  int cyc = 0, checks = 0, errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_rmw_ctrl #(.ADDR_W(6), .BIG_ENDIAN(1'b1)) u_be (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall_be),
    .rdata(rd_be), .rdata_valid(rdv_be), .misalign(mis_be), .mem_addr(ma_be), .mem_we(mwe_be),
    .mem_wdata(mwd_be), .mem_rdata(mrd_be));
  dmem_rmw_ctrl #(.ADDR_W(6), .BIG_ENDIAN(1'b0)) u_le (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall_le),
    .rdata(rd_le), .rdata_valid(rdv_le), .misalign(mis_le), .mem_addr(ma_le), .mem_we(mwe_le),
    .mem_wdata(mwd_le), .mem_rdata(mrd_le));

  // synchronous-read RAMs, read-before-write
  always @(posedge clk)
    if (clr) for (int i = 0; i < 64; i++) begin ram_be[i] <= 0; ram_le[i] <= 0; end
    else begin
      mrd_be <= ram_be[ma_be];
      mrd_le <= ram_le[ma_le];
      if (mwe_be) ram_be[ma_be] <= mwd_be;
      if (mwe_le) ram_le[ma_le] <= mwd_le;
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // e=1 big-endian: byte offset 0 is the most significant byte
  function automatic int bpos(int e, int o);
    return e != 0 ? (3 - o) * 8 : o * 8;
  endfunction

  function automatic logic [7:0] mbyte(int e, int w, int o);
    return mdl[e][w][bpos(e, o) +: 8];
  endfunction

  task automatic model_store(input int e, input int w, input int o, input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2) mdl[e][w] = wd;
    else if (sz == 0) mdl[e][w][bpos(e, o) +: 8] = wd[7:0];
    else begin
      mdl[e][w][bpos(e, o + (e != 0 ? 0 : 1)) +: 8] = wd[15:8];
      mdl[e][w][bpos(e, o + (e != 0 ? 1 : 0)) +: 8] = wd[7:0];
    end
  endtask

  function automatic logic [31:0] model_load(int e, int w, int o, logic [1:0] sz, logic uns);
    logic [15:0] h;
    if (sz == 2) return mdl[e][w];
    if (sz == 0) return uns ? {24'h0, mbyte(e, w, o)} : {{24{mbyte(e, w, o) >= 8'h80}}, mbyte(e, w, o)};
    h = {mbyte(e, w, o + (e != 0 ? 0 : 1)), mbyte(e, w, o + (e != 0 ? 1 : 0))};
    return uns ? {16'h0, h} : {{16{h[15]}}, h};
  endfunction

  task automatic drive(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a, input logic [31:0] wd);
    bit mis, two, wst;
    int w, o;
    mis = sz == 3 || (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 0);
    wst = !mis && we && sz == 2;
    two = !mis && !wst;
    w = int'(a[7:2]);
    o = int'(a[1:0]);
    drive(we, sz, uns, a, wd);
    if (mis) begin q_mis_be.push_back(32'(cyc + 1)); q_mis_le.push_back(32'(cyc + 1)); end
    else for (int e = 0; e < 2; e++)
      if (we) model_store(e, w, o, sz, wd);
      else if (e != 0) q_rd_be.push_back({model_load(e, w, o, sz, uns), 32'(cyc + 2)});
      else q_rd_le.push_back({model_load(e, w, o, sz, uns), 32'(cyc + 2)});
    @(negedge clk);
    chk("stall_c0_be", 32'(stall_be), 32'(two));
    chk("stall_c0_le", 32'(stall_le), 32'(two));
    chk("we_c0_be", 32'(mwe_be), 32'(wst));
    chk("we_c0_le", 32'(mwe_le), 32'(wst));
    if (wst) begin chk("wdata_word_be", mwd_be, wd); chk("wdata_word_le", mwd_le, wd); end
    if (two) begin
      @(negedge clk);
      chk("stall_c1_be", 32'(stall_be), 0);
      chk("stall_c1_le", 32'(stall_le), 0);
      chk("we_c1_be", 32'(mwe_be), 32'(we));
      chk("we_c1_le", 32'(mwe_le), 32'(we));
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    req_valid = 0;
    @(negedge clk);
    chk("idle_stall_be", 32'(stall_be | mwe_be), 0);
    chk("idle_stall_le", 32'(stall_le | mwe_le), 0);
    @(posedge clk); #1;
  endtask

  // scoreboard monitor: every output pulse must match the oldest pending expectation, data and cycle
  always @(negedge clk) if (reset) begin
    if (rdv_be) begin
      if (q_rd_be.size() == 0) chk("rd_be_spurious", 32'(rdv_be), 0);
      else begin x_be = q_rd_be.pop_front(); chk("rd_be_data", rd_be, x_be.d); chk("rd_be_cycle", 32'(cyc), x_be.c); end
    end
    if (rdv_le) begin
      if (q_rd_le.size() == 0) chk("rd_le_spurious", 32'(rdv_le), 0);
      else begin x_le = q_rd_le.pop_front(); chk("rd_le_data", rd_le, x_le.d); chk("rd_le_cycle", 32'(cyc), x_le.c); end
    end
    if (mis_be) begin
      if (q_mis_be.size() == 0) chk("mis_be_spurious", 32'(mis_be), 0);
      else chk("mis_be_cycle", 32'(cyc), q_mis_be.pop_front());
    end
    if (mis_le) begin
      if (q_mis_le.size() == 0) chk("mis_le_spurious", 32'(mis_le), 0);
      else chk("mis_le_cycle", 32'(cyc), q_mis_le.pop_front());
    end
  end

  initial begin
    logic [1:0] sz;
    logic [31:0] a;
    for (int e = 0; e < 2; e++) for (int i = 0; i < 64; i++) mdl[e][i] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata_be", rd_be, 0);
    chk("rst_rdata_le", rd_le, 0);
    chk("rst_pulses_be", {30'h0, rdv_be, mis_be}, 0);
    chk("rst_pulses_le", {30'h0, rdv_le, mis_le}, 0);
    chk("rst_stall_we", {28'h0, stall_be, mwe_be, stall_le, mwe_le}, 0);
    @(negedge clk); reset = 1; clr = 0;
    @(posedge clk); #1;
    do_req(1, 2, 0, 84, 32'h12345678);
    do_req(1, 0, 0, 85, 32'h000000AB);
    chk("plan_sb_be", ram_be[21], 32'h12AB5678);
    chk("plan_sb_le", ram_le[21], 32'h1234AB78);
    do_req(1, 1, 0, 86, 32'hFFFF0000);
    chk("plan_sh_be", ram_be[21], 32'h12AB0000);
    do_req(1, 1, 0, 85, 32'h00001234);
    idle();
    chk("plan_sh_mis_be", ram_be[21], 32'h12AB0000);
    do_req(1, 2, 0, 84, 32'h80AB7F00);
    do_req(0, 0, 0, 84, 0);
    chk("plan_lb_be", rd_be, 32'hFFFFFF80);
    do_req(0, 0, 1, 84, 0);
    chk("plan_lbu_be", rd_be, 32'h00000080);
    do_req(0, 1, 0, 86, 0);
    chk("plan_lh_be", rd_be, 32'h00007F00);
    do_req(0, 2, 0, 84, 0);
    chk("plan_lw_be", rd_be, 32'h80AB7F00);
    do_req(1, 0, 0, 84, 32'h11);
    do_req(1, 0, 0, 87, 32'h22);
    do_req(0, 2, 0, 84, 0);
    chk("plan_b2b_lw_be", rd_be, 32'h11AB7F22);
    chk("plan_b2b_ram_be", ram_be[21], 32'h11AB7F22);
    chk("plan_b2b_ram_le", ram_le[21], 32'h22AB7F11);
    idle();
    chk("rdata_hold_be", rd_be, 32'h11AB7F22);
    // reset during the merge cycle of a byte store
    drive(1, 0, 0, 84, 32'h33);
    @(posedge clk); #1;
    reset = 0; #1;
    chk("rst_merge_we", {30'h0, mwe_be, mwe_le}, 0);
    chk("rst_merge_rdata", rd_be | rd_le, 0);
    chk("rst_merge_pulses", {28'h0, rdv_be, mis_be, rdv_le, mis_le}, 0);
    req_valid = 0;
    @(negedge clk); reset = 1;
    @(posedge clk); #1;
    chk("rst_merge_ram_be", ram_be[21], 32'h11AB7F22);
    chk("rst_merge_ram_le", ram_le[21], 32'h22AB7F11);
    do_req(0, 2, 0, 84, 0);
    // reset during the response cycle of a load
    drive(0, 2, 0, 84, 0);
    @(posedge clk); #1;
    reset = 0; #1;
    chk("rst_lresp_rdv", {30'h0, rdv_be, rdv_le}, 0);
    req_valid = 0;
    @(negedge clk); reset = 1;
    @(posedge clk); #1;
    idle();
    do_req(1, 2, 0, 84, 32'h0);
    do_req(1, 0, 0, 84, 32'hCD);
    chk("plan_le_sb", ram_le[21], 32'h000000CD);
    chk("plan_le_sb_be", ram_be[21], 32'hCD000000);
    do_req(0, 0, 1, 84, 0);
    chk("plan_le_lbu", rd_le, 32'h000000CD);
    for (int n = 0; n < 600; n++) begin
      sz = $urandom_range(0, 7) == 0 ? 2'b11 : 2'($urandom_range(0, 2));
      a = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) < 3 && sz != 2'b11) a[sz == 2'b10 ? 1 : 0] = 1'b0;
      if (sz == 2'b10) a[0] = 1'b0;
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 5) == 0) idle();
    end
    repeat (3) idle();
    chk("q_rd_be_empty", q_rd_be.size(), 0);
    chk("q_rd_le_empty", q_rd_le.size(), 0);
    chk("q_mis_be_empty", q_mis_be.size(), 0);
    chk("q_mis_le_empty", q_mis_le.size(), 0);
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("ram_be[%0d]", i), ram_be[i], mdl[1][i]);
      chk($sformatf("ram_le[%0d]", i), ram_le[i], mdl[0][i]);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
